// File: rtl/proc_pkg.sv
// Shared processor encodings: instruction word layout, idle word and sequencer types.
package proc_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned ISSUED_W = 16;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 13;
  localparam int unsigned RX_MSB = 12;
  localparam int unsigned RX_LSB = 10;
  localparam int unsigned RY_MSB = 9;
  localparam int unsigned RY_LSB = 7;
  localparam int unsigned IMM_W  = RY_LSB;

  // Also decoded by the processor as a no-op.
  localparam logic [INSTR_W-1:0] IDLE_INSTR_ENC = 16'b000_000_000_0000000;

  typedef struct packed {
    logic [OP_MSB-OP_LSB:0] opcode;
    logic [RX_MSB-RX_LSB:0] rx;
    logic [RY_MSB-RY_LSB:0] ry;
    logic [IMM_W-1:0]       imm;
  } instr_t;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_HOLD = 1'b1
  } seq_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction buffer with wrap-bit pointers, occupancy count and flush.
module instr_fifo
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  instr_t                 wr_data_i,
  input  logic                   rd_en_i,
  input  logic                   flush_i,
  output instr_t                 head_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  instr_t        mem_q [DEPTH];
  logic          wr_fire, rd_fire;

  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = count_q;

  assign wr_fire = wr_en_i && !full_c && !flush_i;
  assign rd_fire = rd_en_i && !empty_c;

  // A pop in a flush cycle still consumes the old head; the rest is dropped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Issues queued instructions to the processor iin, each held for HOLD cycles back-to-back.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned          DEPTH      = 8,
  parameter int unsigned          HOLD       = 4,
  parameter logic [INSTR_W-1:0]   IDLE_INSTR = IDLE_INSTR_ENC
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   wr_valid,
  input  logic [INSTR_W-1:0]     wr_data,
  output logic                   wr_ready,
  input  logic                   halt,
  input  logic                   flush,
  output logic [INSTR_W-1:0]     proc_iin,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [ISSUED_W-1:0]    issued
);

  localparam int unsigned    HCW         = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_RELOAD = HCW'(HOLD - 1);

  seq_state_e          state_q, state_d;
  logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [INSTR_W-1:0]  iin_q, iin_d;
  logic                busy_q, busy_d;
  logic [ISSUED_W-1:0] issued_q, issued_d;
  logic                ready_en_q;
  logic                pop_c, start_c;
  instr_t              head_c;
  logic                fifo_full_c, fifo_empty_c;

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (resetn),
    .wr_en_i   (wr_valid && wr_ready),
    .wr_data_i (instr_t'(wr_data)),
    .rd_en_i   (pop_c),
    .flush_i   (flush),
    .head_c    (head_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c),
    .count_o   (count)
  );

  // ready_en_q keeps the host stalled until the first edge after reset release.
  assign wr_ready = ready_en_q && !fifo_full_c && !flush;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    iin_d      = iin_q;
    busy_d     = busy_q;
    issued_d   = issued_q;
    pop_c      = 1'b0;
    start_c    = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty_c && !halt) start_c = 1'b1;
      end
      SEQ_HOLD: begin
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - HCW'(1);
        end else if (!fifo_empty_c && !halt) begin
          start_c = 1'b1;
        end else begin
          state_d = SEQ_IDLE;
          iin_d   = IDLE_INSTR;
          busy_d  = 1'b0;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    // Common issue path: take the head and start a fresh hold window.
    if (start_c) begin
      pop_c      = 1'b1;
      state_d    = SEQ_HOLD;
      iin_d      = head_c;
      hold_cnt_d = HOLD_RELOAD;
      busy_d     = 1'b1;
      issued_d   = issued_q + ISSUED_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= SEQ_IDLE;
      hold_cnt_q <= '0;
      iin_q      <= IDLE_INSTR;
      busy_q     <= 1'b0;
      issued_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      iin_q      <= iin_d;
      busy_q     <= busy_d;
      issued_q   <= issued_d;
      ready_en_q <= 1'b1;
    end
  end

  assign proc_iin = iin_q;
  assign busy     = busy_q;
  assign issued   = issued_q;

endmodule
